mc_controller: RTL and testbench

Multicycle RISC-V control unit: a Moore FSM that sequences each instruction over 3–5 states (more with memory wait states) so the datapath can share one memory and one ALU. Sits beside the multicycle datapath in place of the single-cycle controller. Adds:
- a memory-ready handshake for variable-latency memory;
- beq/bne/blt/bge resolution;
- a parametrised ALU-control width;
- an optional multiply/divide handshake.

---
 rtl/mc_pkg.sv | 75 +++++++
 rtl/mc_controller_aludec.sv | 47 ++++
 rtl/mc_controller.sv | 233 +++++++++++++++++++++++
 tb/tb_mc_controller.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared types and encodings for the multicycle RISC-V controller.
//
// Contents:
//   state_t        FSM state enum (S_MULDIV exists only when MULDIV_EN is defined)
//   aluop_t        ALU operation class handed from the FSM to the ALU decoder
//   OP_*           supported opcodes
//   ALU_*          3-bit ALU control codes (zero-extended by the decoder)
//   IMM_*, RES_*, SRCA_*, SRCB_*  datapath mux encodings
//   imm_src_of()   opcode -> ImmSrc decode
//
// Optional feature macro: MULDIV_EN (adds the multiply/divide state).
package mc_pkg;

`ifdef MULDIV_EN
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_MULDIV
    } state_t;
`else
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL
    } state_t;
`endif

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_BTYPE = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT = 2'b00;  // registered ALU result
    localparam logic [1:0] RES_DATA   = 2'b01;  // memory read data
    localparam logic [1:0] RES_ALU    = 2'b10;  // live ALU result (PC+4)
    localparam logic [1:0] RES_MD     = 2'b11;  // multiply/divide result

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    // Opcodes without an immediate (R-type, unknown) fall back to I format.
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        logic [1:0] r;
        case (op)
            OP_STORE: r = IMM_S;
            OP_BTYPE: r = IMM_B;
            OP_JAL:   r = IMM_J;
            default:  r = IMM_I;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mc_controller_aludec.sv
// aludec: ALU control decoder for the multicycle controller.
//
// Ports:
//   ALUOp       in   operation class from the FSM (add / sub / funct)
//   funct3      in   instruction funct3
//   funct7b5    in   instruction bit 30
//   op5         in   opcode bit 5 (distinguishes R-type from I-ALU)
//   ALUControl  out  ALUCTRL_W-bit control code, upper bits zero
module aludec
    import mc_pkg::*;
#(
    parameter int ALUCTRL_W = 3
) (
    input  aluop_t               ALUOp,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 op5,
    output logic [ALUCTRL_W-1:0] ALUControl
);

    logic [2:0] code;

    always_comb begin
        code = ALU_ADD;
        case (ALUOp)
            ALUOP_ADD: code = ALU_ADD;
            ALUOP_SUB: code = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // funct7b5 only means "sub" for R-type; for addi it is immediate bit
                    3'b000:  code = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  code = ALU_SLT;
                    3'b110:  code = ALU_OR;
                    3'b111:  code = ALU_AND;
                    default: code = ALU_ADD;
                endcase
            end
            default: code = ALU_ADD;
        endcase
    end

    always_comb begin
        ALUControl      = '0;
        ALUControl[2:0] = code;
    end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle RISC-V control unit (Moore FSM).
//
// Sequences each instruction over several states so the datapath can share
// one memory and one ALU. Memory accesses in FETCH/MEMREAD/MEMWRITE wait
// for mem_ready. Branch resolution and ImmSrc decode are done here; ALU
// control decode lives in aludec.
//
// Ports:
//   clk, reset              clock (rising edge), synchronous active-high reset
//   op, funct3, funct7b5    instruction fields
//   funct7b0                M-extension select (MULDIV_EN only)
//   Zero[FLAG_W]            bit0 = ALU zero, bit1 = signed less-than
//   mem_ready               memory access completes this cycle
//   md_done                 multiply/divide result valid (MULDIV_EN only)
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite            1-bit controls
//   ResultSrc, ALUSrcA, ALUSrcB, ImmSrc                     2-bit selects
//   ALUControl[ALUCTRL_W]   ALU operation code
//   md_start                one-cycle start pulse to the mul/div unit
//   illegal                 one-cycle pulse in DECODE for unsupported opcodes
//
// Optional feature macro: MULDIV_EN (adds the MULDIV state and handshake).
module mc_controller
    import mc_pkg::*;
#(
    parameter int ALUCTRL_W = 3,
    parameter int FLAG_W    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 funct7b0,
    input  logic [FLAG_W-1:0]    Zero,
    input  logic                 mem_ready,
    input  logic                 md_done,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 RegWrite,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 md_start,
    output logic                 illegal
);

    state_t state_q, state_d;
    state_t st;          // state seen by the output decode (FETCH while in reset)
    aluop_t alu_op;

    logic pc_update, branch, taken;
    logic mem_write_raw, ir_write_raw, reg_write_raw, illegal_raw, md_start_raw;

`ifdef MULDIV_EN
    logic md_first_q;    // first cycle of the current MULDIV visit
    logic md_wb_q;       // ALUWB is writing back a mul/div result
`else
    logic unused_md;
    assign unused_md = funct7b0 ^ md_done;
`endif

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
`ifdef MULDIV_EN
                    OP_RTYPE:          state_d = funct7b0 ? S_MULDIV : S_EXECR;
`else
                    OP_RTYPE:          state_d = S_EXECR;
`endif
                    OP_IALU:           state_d = S_EXECI;
                    OP_BTYPE:          state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
`ifdef MULDIV_EN
            S_MULDIV:   if (md_done) state_d = S_ALUWB;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef MULDIV_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            md_first_q <= 1'b0;
            md_wb_q    <= 1'b0;
        end else begin
            md_first_q <= (state_d == S_MULDIV) && (state_q != S_MULDIV);
            md_wb_q    <= (state_q == S_MULDIV) && (state_d == S_ALUWB);
        end
    end
`endif

    // Branch resolution from ALU flags of rs1 - rs2
    always_comb begin
        case (funct3)
            3'b000:  taken = Zero[0];
            3'b001:  taken = ~Zero[0];
            3'b100:  taken = Zero[1];
            3'b101:  taken = ~Zero[1];
            default: taken = 1'b0;
        endcase
    end

    // Output decode; reset presents FETCH selects with all enables masked
    assign st = reset ? S_FETCH : state_q;

    always_comb begin
        pc_update     = 1'b0;
        branch        = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        illegal_raw   = 1'b0;
        md_start_raw  = 1'b0;
        AdrSrc        = 1'b0;
        ResultSrc     = RES_ALUOUT;
        ALUSrcA       = SRCA_PC;
        ALUSrcB       = SRCB_RS2;
        alu_op        = ALUOP_ADD;
        case (st)
            S_FETCH: begin
                ALUSrcB      = SRCB_FOUR;
                ResultSrc    = RES_ALU;
                ir_write_raw = mem_ready;
                pc_update    = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE, OP_RTYPE, OP_IALU, OP_BTYPE, OP_JAL: illegal_raw = 1'b0;
                    default: illegal_raw = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc     = RES_DATA;
                reg_write_raw = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc        = 1'b1;
                mem_write_raw = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_RS1;
                alu_op  = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
`ifdef MULDIV_EN
                ResultSrc     = md_wb_q ? RES_MD : RES_ALUOUT;
`endif
            end
            S_BRANCH: begin
                ALUSrcA = SRCA_RS1;
                alu_op  = ALUOP_SUB;
                branch  = 1'b1;
            end
            S_JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                pc_update = 1'b1;
            end
`ifdef MULDIV_EN
            S_MULDIV: begin
                md_start_raw = md_first_q;
            end
`endif
            default: begin
                pc_update = 1'b0;
            end
        endcase
    end

    assign PCWrite  = ~reset & (pc_update | (branch & taken));
    assign IRWrite  = ~reset & ir_write_raw;
    assign MemWrite = ~reset & mem_write_raw;
    assign RegWrite = ~reset & reg_write_raw;
    assign illegal  = ~reset & illegal_raw;
    assign md_start = ~reset & md_start_raw;

    assign ImmSrc = imm_src_of(op);

    aludec #(
        .ALUCTRL_W (ALUCTRL_W)
    ) u_aludec (
        .ALUOp      (alu_op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .op5        (op[5]),
        .ALUControl (ALUControl)
    );

endmodule

// File: tb/tb_mc_controller.sv
// Testbench for mc_controller: directed instruction sequences, expected
// control vectors queued per cycle, compared by an independent monitor.
// Vector layout: {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
//                 ALUSrcA, ALUSrcB, ImmSrc, ALUControl, md_start, illegal}
module tb_mc_controller;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       funct7b0;
    logic [1:0] Zero;
    logic       mem_ready;
    logic       md_done;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic       md_start, illegal;

    typedef struct {
        string      nm;
        logic [17:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;

    mc_controller #(.ALUCTRL_W(3), .FLAG_W(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .funct7b0   (funct7b0),
        .Zero       (Zero),
        .mem_ready  (mem_ready),
        .md_done    (md_done),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .md_start   (md_start),
        .illegal    (illegal)
    );

    // First edge is a falling edge so the first queued vector is checked
    // before the first rising edge.
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    function automatic logic [17:0] E(input logic pcw, input logic adr, input logic memw,
                                      input logic irw, input logic regw, input logic [1:0] rs,
                                      input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] imm, input logic [2:0] alu,
                                      input logic mds, input logic ill);
        return {pcw, adr, memw, irw, regw, rs, a, b, imm, alu, mds, ill};
    endfunction

    // Monitor: compares every cycle for which an expectation was queued
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [17:0] act;
            e   = exp_q.pop_front();
            act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                   ALUSrcA, ALUSrcB, ImmSrc, ALUControl, md_start, illegal};
            checks++;
            if (act !== e.v) begin
                fails++;
                $display("FAIL %s actual=%b required=%b", e.nm, act, e.v);
            end
        end
    end

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3,
                             input logic f7b5, input logic f7b0);
        op       = o;
        funct3   = f3;
        funct7b5 = f7b5;
        funct7b0 = f7b0;
    endtask

    task automatic cyc(input string nm, input logic mr, input logic [1:0] z,
                       input logic rst, input logic [17:0] v);
        exp_t e;
        mem_ready = mr;
        Zero      = z;
        reset     = rst;
        e.nm      = nm;
        e.v       = v;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Common 4-cycle R/I-type flow with hand-computed EXEC vector
    task automatic run_alu(input string nm, input logic [17:0] exec_v);
        cyc({nm, "_fetch"},  1'b1, 2'b00, 1'b0, E(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
        cyc({nm, "_decode"}, 1'b1, 2'b00, 1'b0, E(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0));
        cyc({nm, "_exec"},   1'b0, 2'b00, 1'b0, exec_v);
        cyc({nm, "_aluwb"},  1'b0, 2'b00, 1'b0, E(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0,0));
    endtask

    task automatic run_branch(input string nm, input logic [2:0] f3,
                              input logic [1:0] z, input logic pcw);
        set_instr(7'b1100011, f3, 1'b0, 1'b0);
        cyc({nm, "_fetch"},  1'b1, 2'b00, 1'b0, E(1,0,0,1,0,2'b10,2'b00,2'b10,2'b10,3'b000,0,0));
        cyc({nm, "_decode"}, 1'b1, 2'b00, 1'b0, E(0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000,0,0));
        cyc({nm, "_branch"}, 1'b1, z,     1'b0, E(pcw,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001,0,0));
    endtask

    initial begin
        md_done = 1'b0;
        set_instr(7'b0110011, 3'b000, 1'b0, 1'b0);

        // Reset: FETCH selects, all enables masked even with mem_ready=1
        cyc("reset", 1'b1, 2'b00, 1'b1, E(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));

        // add x3,x1,x2
        run_alu("add", E(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b000,0,0));

        // lw: 2 FETCH waits, 3 MEMREAD waits -> 10 cycles
        set_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
        cyc("lw_fetch_w1", 1'b0, 2'b00, 1'b0, E(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
        cyc("lw_fetch_w2", 1'b0, 2'b00, 1'b0, E(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
        cyc("lw_fetch",    1'b1, 2'b00, 1'b0, E(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
        cyc("lw_decode",   1'b0, 2'b00, 1'b0, E(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0));
        cyc("lw_memadr",   1'b0, 2'b00, 1'b0, E(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0,0));
        for (int i = 0; i < 3; i++)
            cyc("lw_memread_w", 1'b0, 2'b00, 1'b0, E(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,0));
        cyc("lw_memread",  1'b1, 2'b00, 1'b0, E(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,0));
        cyc("lw_memwb",    1'b0, 2'b00, 1'b0, E(0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,3'b000,0,0));

        // sw interrupted by reset in MEMWRITE, then a complete sw
        set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
        cyc("sw_fetch",    1'b1, 2'b00, 1'b0, E(1,0,0,1,0,2'b10,2'b00,2'b10,2'b01,3'b000,0,0));
        cyc("sw_decode",   1'b1, 2'b00, 1'b0, E(0,0,0,0,0,2'b00,2'b01,2'b01,2'b01,3'b000,0,0));
        cyc("sw_memadr",   1'b1, 2'b00, 1'b0, E(0,0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b000,0,0));
        cyc("sw_memwr_w",  1'b0, 2'b00, 1'b0, E(0,1,1,0,0,2'b00,2'b00,2'b00,2'b01,3'b000,0,0));
        cyc("sw_rst",      1'b0, 2'b00, 1'b1, E(0,0,0,0,0,2'b10,2'b00,2'b10,2'b01,3'b000,0,0));
        cyc("sw_postrst",  1'b0, 2'b00, 1'b0, E(0,0,0,0,0,2'b10,2'b00,2'b10,2'b01,3'b000,0,0));
        cyc("sw2_fetch",   1'b1, 2'b00, 1'b0, E(1,0,0,1,0,2'b10,2'b00,2'b10,2'b01,3'b000,0,0));
        cyc("sw2_decode",  1'b1, 2'b00, 1'b0, E(0,0,0,0,0,2'b00,2'b01,2'b01,2'b01,3'b000,0,0));
        cyc("sw2_memadr",  1'b1, 2'b00, 1'b0, E(0,0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b000,0,0));
        cyc("sw2_memwr_w", 1'b0, 2'b00, 1'b0, E(0,1,1,0,0,2'b00,2'b00,2'b00,2'b01,3'b000,0,0));
        cyc("sw2_memwr",   1'b1, 2'b00, 1'b0, E(0,1,1,0,0,2'b00,2'b00,2'b00,2'b01,3'b000,0,0));

        // ALU decode variants
        set_instr(7'b0110011, 3'b000, 1'b1, 1'b0);
        run_alu("sub",  E(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b001,0,0));
        set_instr(7'b0010011, 3'b110, 1'b0, 1'b0);
        run_alu("ori",  E(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b011,0,0));
        set_instr(7'b0010011, 3'b000, 1'b1, 1'b0);
        run_alu("addi_b30", E(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0,0));
        set_instr(7'b0110011, 3'b111, 1'b0, 1'b0);
        run_alu("and",  E(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b010,0,0));
        set_instr(7'b0110011, 3'b010, 1'b0, 1'b0);
        run_alu("slt",  E(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b101,0,0));

        // Branches
        run_branch("bne_tk",  3'b001, 2'b00, 1'b1);
        run_branch("bne_nt",  3'b001, 2'b01, 1'b0);
        run_branch("beq_tk",  3'b000, 2'b01, 1'b1);
        run_branch("bge_nt",  3'b101, 2'b10, 1'b0);
        run_branch("blt_tk",  3'b100, 2'b10, 1'b1);
        run_branch("f3_010",  3'b010, 2'b11, 1'b0);

        // jal
        set_instr(7'b1101111, 3'b000, 1'b0, 1'b0);
        cyc("jal_fetch",  1'b1, 2'b00, 1'b0, E(1,0,0,1,0,2'b10,2'b00,2'b10,2'b11,3'b000,0,0));
        cyc("jal_decode", 1'b1, 2'b00, 1'b0, E(0,0,0,0,0,2'b00,2'b01,2'b01,2'b11,3'b000,0,0));
        cyc("jal_jal",    1'b1, 2'b00, 1'b0, E(1,0,0,0,0,2'b00,2'b01,2'b10,2'b11,3'b000,0,0));
        cyc("jal_aluwb",  1'b1, 2'b00, 1'b0, E(0,0,0,0,1,2'b00,2'b00,2'b00,2'b11,3'b000,0,0));

        // Illegal opcode
        set_instr(7'b1111111, 3'b000, 1'b0, 1'b0);
        cyc("ill_fetch",  1'b1, 2'b00, 1'b0, E(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
        cyc("ill_decode", 1'b1, 2'b00, 1'b0, E(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,1));
        cyc("ill_refetch", 1'b0, 2'b00, 1'b0, E(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
        cyc("ill_fetch2", 1'b1, 2'b00, 1'b0, E(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
        cyc("ill_decode2", 1'b1, 2'b00, 1'b0, E(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,1));

`ifdef MULDIV_EN
        // mul: md_done in the 5th MULDIV cycle
        set_instr(7'b0110011, 3'b000, 1'b0, 1'b1);
        cyc("mul_fetch",  1'b1, 2'b00, 1'b0, E(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
        cyc("mul_decode", 1'b1, 2'b00, 1'b0, E(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0));
        cyc("mul_md1",    1'b1, 2'b00, 1'b0, E(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,1,0));
        for (int i = 0; i < 3; i++)
            cyc("mul_mdw", 1'b1, 2'b00, 1'b0, E(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,0));
        md_done = 1'b1;
        cyc("mul_md5",    1'b1, 2'b00, 1'b0, E(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,0));
        md_done = 1'b0;
        cyc("mul_aluwb",  1'b1, 2'b00, 1'b0, E(0,0,0,0,1,2'b11,2'b00,2'b00,2'b00,3'b000,0,0));
`else
        // Without the mul/div option, funct7b0 is ignored: plain add flow
        set_instr(7'b0110011, 3'b000, 1'b0, 1'b1);
        run_alu("mul_as_add", E(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b000,0,0));
`endif

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 8 && exp_q.size() > 0; i++)
            @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            checks++;
            fails++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
